// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential fetch, in-order response collection into a
// prefetch queue, redirect flush. Optional perf counters under `IFETCH_PERF_EN.
module ifetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0] perf_redirects,
   output logic [31:0] perf_dropped
`endif
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [31:0]   q_inst [DEPTH];
   logic [31:0]   q_pc   [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   // Outstanding/drop counts can exceed DEPTH across repeated redirects, so they are wide.
   logic [15:0]   o_cnt;
   logic [15:0]   d_cnt;
   logic [15:0]   o_next;
   logic [15:0]   live;
   logic [16:0]   credit_used;
   logic          rsp_fire;
   logic          rsp_drop;
   logic          push;
   logic          pop;
   logic          req_fire;
   logic [31:0]   redirect_aligned;

   assign live             = o_cnt - d_cnt;
   assign credit_used      = 17'(count) + {1'b0, live};
   assign imem_req_valid   = rst_n && !redirect_valid && (credit_used < DEPTH_W);
   assign imem_req_addr    = fetch_pc;
   assign req_fire         = imem_req_valid && imem_req_ready;
   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp_fire         = imem_rsp_valid && (o_cnt != '0);
   assign rsp_drop         = rsp_fire && (redirect_valid || (d_cnt != '0));
   assign push             = rsp_fire && !rsp_drop;
   assign out_valid        = (count != '0) && !redirect_valid;
   assign pop              = out_valid && out_ready;
   assign out_inst         = (count != '0) ? q_inst[rd_ptr] : '0;
   assign out_pc           = (count != '0) ? q_pc[rd_ptr] : '0;
   assign redirect_aligned = {redirect_pc[31:2], 2'b00};

   always_comb begin
      o_next = o_cnt;
      if (req_fire && !rsp_fire) begin
         o_next = o_cnt + 16'd1;
      end else if (!req_fire && rsp_fire) begin
         o_next = o_cnt - 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         o_cnt    <= '0;
         d_cnt    <= '0;
      end else begin
         o_cnt <= o_next;
         if (redirect_valid) begin
            // Everything still in flight belongs to the abandoned path.
            fetch_pc <= redirect_aligned;
            rsp_pc   <= redirect_aligned;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            d_cnt    <= o_next;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (rsp_fire && (d_cnt != '0)) d_cnt <= d_cnt - 16'd1;
            if (push) begin
               wr_ptr <= wr_ptr + 1'b1;
               rsp_pc <= rsp_pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_inst[wr_ptr] <= imem_rsp_data;
         q_pc[wr_ptr]   <= rsp_pc;
      end
   end

`ifdef IFETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_redirects <= '0;
         perf_dropped   <= '0;
      end else begin
         if (redirect_valid && (perf_redirects != '1)) perf_redirects <= perf_redirects + 32'd1;
         if (rsp_drop && (perf_dropped != '1)) perf_dropped <= perf_dropped + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: vector table, directed corner sequences, and randomized
// traffic checked against a queue-based fetch model.
module tb_ifetch_queue;
   localparam int DEPTH = 4;
   localparam logic [31:0] K = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_redirects;
   logic [31:0] perf_dropped;
`endif

   logic        mem_auto = 1'b0;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic        drv_rsp_valid = 1'b0;
   logic [31:0] drv_rsp_data = '0;
   int          mem_lat = 1;

   assign imem_rsp_valid = mem_auto ? mem_rsp_valid : drv_rsp_valid;
   assign imem_rsp_data  = mem_auto ? mem_rsp_data  : drv_rsp_data;

   int compared = 0;
   int mismatched = 0;

   ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc)
`ifdef IFETCH_PERF_EN
      ,
      .perf_redirects (perf_redirects),
      .perf_dropped   (perf_dropped)
`endif
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- fixed-latency memory for directed sequences ----------------
   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;
   mreq_t mem_q[$];
   int    tick = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n || !mem_auto) mem_q.delete();
         else if (imem_req_valid && imem_req_ready) mem_q.push_back('{imem_req_addr, tick + mem_lat});
         @(posedge clk);
         #1;
         tick++;
         mem_rsp_valid = 1'b0;
         if (mem_q.size() > 0 && mem_q[0].due <= tick) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_q[0].addr ^ K;
            void'(mem_q.pop_front());
         end
      end
   end

   // ---------------- driver / checker tasks ----------------
   task automatic chk1(input string name, input logic act, input logic exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b0;
      out_ready      = 1'b0;
      drv_rsp_valid  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_first_out(input string name, input logic [31:0] exp_pc);
      logic found;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         next_cycle();
         @(negedge clk);
         if (out_valid) begin
            found = 1'b1;
            chk32({name, "_pc"}, out_pc, exp_pc);
            chk32({name, "_inst"}, out_inst, exp_pc ^ K);
         end
      end
      chk1({name, "_seen"}, found, 1'b1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        redir;
      logic [31:0] rpc;
      logic        rrdy;
      logic        rspv;
      logic [31:0] rspd;
      logic        ordy;
      logic        e_rv;
      logic [31:0] e_addr;
      logic        e_ov;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   // ---------------- random-phase reference model ----------------
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          epoch;
      int          due;
   } pend_t;
   pend_t       pend[$];
   logic [63:0] exp_q[$];

   initial begin
      vec_t        vt[9];
      logic [31:0] wrap_exp[3];
      int          acc;
      int          epoch;
      int          live;
      logic [31:0] m_next;
      logic        e_rv, e_ov, keep;
      pend_t       f;
      logic [63:0] kept;

      vt[0] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0};
      vt[1] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA5A5_0000, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 32'h0};
      vt[2] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA5A5_0004, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 32'hA5A5_0000};
      vt[3] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA5A5_0008, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4, 32'hA5A5_0004};
      vt[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA5A5_000C, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 32'hA5A5_0008};
      vt[5] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA5A5_0010, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC, 32'hA5A5_000C};
      vt[6] = '{1'b1, 32'h40, 1'b1, 1'b1, 32'hA5A5_0014, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0};
      vt[7] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 32'h0};
      vt[8] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 32'h0};
      wrap_exp[0] = 32'hFFFF_FFF8;
      wrap_exp[1] = 32'hFFFF_FFFC;
      wrap_exp[2] = 32'h0000_0000;

      // Reset values while rst_n is held low.
      @(negedge clk);
      chk1("rst_req_valid", imem_req_valid, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk32("rst_out_inst", out_inst, 32'h0);
      chk32("rst_out_pc", out_pc, 32'h0);
      chk32("rst_req_addr", imem_req_addr, 32'h0);

      // Table: streaming with a 1-cycle memory, then a redirect with a coincident response.
      mem_auto = 1'b0;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         redirect_valid = vt[i].redir;
         redirect_pc    = vt[i].rpc;
         imem_req_ready = vt[i].rrdy;
         drv_rsp_valid  = vt[i].rspv;
         drv_rsp_data   = vt[i].rspd;
         out_ready      = vt[i].ordy;
         @(negedge clk);
         chk1($sformatf("vec%0d_req_valid", i), imem_req_valid, vt[i].e_rv);
         if (vt[i].e_rv) chk32($sformatf("vec%0d_req_addr", i), imem_req_addr, vt[i].e_addr);
         chk1($sformatf("vec%0d_out_valid", i), out_valid, vt[i].e_ov);
         if (vt[i].e_ov) begin
            chk32($sformatf("vec%0d_out_pc", i), out_pc, vt[i].e_pc);
            chk32($sformatf("vec%0d_out_inst", i), out_inst, vt[i].e_inst);
         end
         next_cycle();
      end

      // Reset with a request in flight; a late response must be ignored.
      imem_req_ready = 1'b1;
      drv_rsp_valid  = 1'b0;
      next_cycle();
      do_reset();
      drv_rsp_valid = 1'b1;
      drv_rsp_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      chk1("midrst_out_valid0", out_valid, 1'b0);
      chk32("midrst_req_addr", imem_req_addr, 32'h0);
      next_cycle();
      drv_rsp_valid = 1'b0;
      @(negedge clk);
      chk1("midrst_stray_ignored", out_valid, 1'b0);

      // Backpressure: exactly DEPTH requests, then one pop frees one credit.
      mem_auto = 1'b1;
      mem_lat  = 1;
      do_reset();
      imem_req_ready = 1'b1;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) begin
            chk32($sformatf("bp_addr%0d", acc), imem_req_addr, 32'(acc * 4));
            acc++;
         end
         next_cycle();
      end
      chk32("bp_accepts", 32'(acc), 32'd4);
      out_ready = 1'b1;
      @(negedge clk);
      chk1("bp_pop_valid", out_valid, 1'b1);
      chk32("bp_pop_pc", out_pc, 32'h0);
      chk32("bp_pop_inst", out_inst, K);
      chk1("bp_no_credit_same_cycle", imem_req_valid, 1'b0);
      next_cycle();
      out_ready = 1'b0;
      @(negedge clk);
      chk1("bp_credit_back", imem_req_valid, 1'b1);
      chk32("bp_next_addr", imem_req_addr, 32'h10);
      chk32("bp_next_head", out_pc, 32'h4);

      // Redirect with two requests outstanding on a 3-cycle memory.
      mem_lat = 3;
      do_reset();
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      next_cycle();
      next_cycle();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      @(negedge clk);
      chk1("rd_cycle_req_valid", imem_req_valid, 1'b0);
      chk1("rd_cycle_out_valid", out_valid, 1'b0);
      next_cycle();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      @(negedge clk);
      chk1("rd_req_valid", imem_req_valid, 1'b1);
      chk32("rd_req_addr", imem_req_addr, 32'h100);
      wait_first_out("rd_first", 32'h100);
`ifdef IFETCH_PERF_EN
      chk32("perf_redirects", perf_redirects, 32'd1);
      chk32("perf_dropped", perf_dropped, 32'd2);
`endif

      // Response coincident with redirect while the queue holds an entry.
      mem_lat = 1;
      do_reset();
      imem_req_ready = 1'b1;
      next_cycle();
      next_cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      @(negedge clk);
      chk1("coinc_out_valid", out_valid, 1'b0);
      chk1("coinc_req_valid", imem_req_valid, 1'b0);
      next_cycle();
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      @(negedge clk);
      chk1("coinc_flushed", out_valid, 1'b0);
      wait_first_out("coinc_first", 32'h200);

      // Address wrap.
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      next_cycle();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready && acc < 3) begin
            chk32($sformatf("wrap_addr%0d", acc), imem_req_addr, wrap_exp[acc]);
            acc++;
         end
         next_cycle();
      end
      chk32("wrap_accepts", 32'(acc), 32'd3);

      // Randomized traffic against the reference model.
      mem_auto = 1'b0;
      do_reset();
      pend.delete();
      exp_q.delete();
      epoch  = 0;
      m_next = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
         imem_req_ready = ($urandom_range(0, 3) != 0);
         out_ready      = ($urandom_range(0, 3) != 0);
         drv_rsp_valid  = 1'b0;
         drv_rsp_data   = $urandom;
         if (pend.size() > 0 && pend[0].due <= c && $urandom_range(0, 3) != 0) begin
            drv_rsp_valid = 1'b1;
            drv_rsp_data  = pend[0].data;
         end
         @(negedge clk);
         live = 0;
         foreach (pend[j]) if (pend[j].epoch == epoch) live++;
         e_rv = !redirect_valid && (exp_q.size() + live < DEPTH);
         e_ov = !redirect_valid && (exp_q.size() > 0);
         chk1($sformatf("rnd%0d_req_valid", c), imem_req_valid, e_rv);
         if (e_rv) chk32($sformatf("rnd%0d_req_addr", c), imem_req_addr, m_next);
         chk1($sformatf("rnd%0d_out_valid", c), out_valid, e_ov);
         if (e_ov) begin
            chk32($sformatf("rnd%0d_out_pc", c), out_pc, exp_q[0][63:32]);
            chk32($sformatf("rnd%0d_out_inst", c), out_inst, exp_q[0][31:0]);
         end
         keep = 1'b0;
         kept = '0;
         if (drv_rsp_valid) begin
            f = pend.pop_front();
            if (!redirect_valid && f.epoch == epoch) begin
               keep = 1'b1;
               kept = {f.addr, f.data};
            end
         end
         if (e_ov && out_ready) void'(exp_q.pop_front());
         if (keep) exp_q.push_back(kept);
         if (redirect_valid) begin
            exp_q.delete();
            epoch++;
            m_next = {redirect_pc[31:2], 2'b00};
         end else if (e_rv && imem_req_ready) begin
            pend.push_back('{m_next, $urandom, epoch, c + 1 + int'($urandom_range(0, 3))});
            m_next = m_next + 32'd4;
         end
         next_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
